// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Converts a WIDTH-bit binary value to DIGITS packed BCD digits. It feeds the
// 7-segment display driver. The last result is held until the next conversion completes.
//
// Ports
//   clk    system clock, all state changes on posedge
//   rst    asynchronous active-low reset
//   start  conversion request, sampled only while idle
//   bin    binary value, captured on the accepting edge
//   busy   high while a conversion is in progress
//   done   one-cycle pulse; bcd/ovf are valid from this cycle on
//   bcd    packed BCD, digit 0 in [3:0]
//   ovf    value >= 10**DIGITS; bcd then holds the low DIGITS digits

// Per-nibble adjust: a digit >= 5 would carry past 9 once it is doubled, so pre-add 3.
module bin2bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf
);
  // One extra nibble above the visible digits acts as the overflow guard.
  localparam int NIB = DIGITS + 1;
  localparam int AW  = NIB * 4;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [AW-1:0]    acc, acc_adj, acc_nxt;
  logic [CW-1:0]    cnt;

  generate
    for (genvar i = 0; i < NIB; i++) begin : g_nib
      bin2bcd_add3 u_add3 (.d(acc[i*4 +: 4]), .q(acc_adj[i*4 +: 4]));
    end
  endgenerate

  // Adjusted accumulator shifted left, with the next binary MSB entering at bit 0.
  assign acc_nxt = {acc_adj[AW-2:0], shreg[WIDTH-1]};
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        shreg <= bin;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
        state <= SHIFT;
      end
    end else begin
      acc   <= acc_nxt;
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt - CW'(1);
      // Last bit enters this edge: publish straight from the next-state value.
      if (cnt == CW'(1)) begin
        bcd   <= acc_nxt[DIGITS*4-1:0];
        ovf   <= |acc_nxt[AW-1 -: 4];
        done  <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [12:0] bin_a = '0;
  logic [13:0] bin_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] bcd_a, bcd_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic sel = 1'b0;  // 0 = 13-bit instance, 1 = 14-bit instance

  bin2bcd_seq #(.WIDTH(13), .DIGITS(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));

  always #5 clk = ~clk;

  logic        c_busy, c_done, c_ovf;
  logic [15:0] c_bcd;
  assign c_busy = sel ? busy_b : busy_a;
  assign c_done = sel ? done_b : done_a;
  assign c_ovf  = sel ? ovf_b  : ovf_a;
  assign c_bcd  = sel ? bcd_b  : bcd_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the value by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic convert(input bit s, input int unsigned v);
    int n, nb, wid;
    logic [15:0] eb;
    sel = s;
    wid = s ? 14 : 13;
    eb  = ref_bcd(v);
    @(negedge clk);
    if (s) begin start_b = 1'b1; bin_b = v[13:0]; end
    else   begin start_a = 1'b1; bin_a = v[12:0]; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    bin_a = 13'($urandom); bin_b = 14'($urandom);  // must not disturb the conversion
    n = 0; nb = 0;
    while (!c_done && n < 40) begin
      if (c_busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, wid);
    chk("busy_cycles", nb, wid);
    chk("bcd", c_bcd, eb);
    chk("ovf", c_ovf, (v >= 10000) ? 1 : 0);
    chk("busy_at_done", c_busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", c_done, 0);
    chk("bcd_hold", c_bcd, eb);
  endtask

  initial begin
    int t, nd, t1, t2;
    logic [15:0] r1, r2;

    // 1) reset and idle hold
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    chk("rst_bcd", bcd_a, 0);   chk("rst_ovf", ovf_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_hold", {busy_a, done_a, ovf_a, bcd_a, busy_b, done_b}, 0);
    end

    // 2) zero, 3) maxima
    convert(0, 0);
    convert(0, 8191);
    convert(0, 4095);

    // 4) sustained start: 1234 then 5678, one result every 14 cycles
    sel = 0;
    @(negedge clk); start_a = 1'b1; bin_a = 13'd1234;
    @(posedge clk); #1;
    bin_a = 13'd5678;
    t = 0; nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    while (nd < 2 && t < 60) begin
      @(posedge clk); #1; t++;
      if (done_a) begin
        nd++;
        if (nd == 1) begin t1 = t; r1 = bcd_a; end
        else begin t2 = t; r2 = bcd_a; start_a = 1'b0; end
      end
    end
    start_a = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_first_lat", t1, 13);
    chk("b2b_period", t2 - t1, 14);
    chk("b2b_first", r1, 16'h1234);
    chk("b2b_second", r2, 16'h5678);

    // start pulses while busy are ignored
    @(negedge clk); start_a = 1'b1; bin_a = 13'd1111;
    @(negedge clk); start_a = 1'b0; bin_a = 13'd2222;
    nd = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      start_a = (i == 3 || i == 7);
      if (done_a) nd++;
    end
    start_a = 1'b0;
    chk("busy_start_ignored", nd, 1);
    chk("busy_start_bcd", bcd_a, 16'h1111);

    // random values on both widths
    for (int i = 0; i < 16; i++) convert(0, $urandom_range(0, 8191));
    for (int i = 0; i < 6; i++)  convert(1, $urandom_range(0, 16383));

    // 6) wider instance boundaries
    convert(1, 16383);
    convert(1, 9999);
    convert(1, 10000);

    // 5) reset mid-conversion
    convert(0, 7777);
    sel = 0;
    @(negedge clk); start_a = 1'b1; bin_a = 13'd3333;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0); chk("abort_done", done_a, 0);
    chk("abort_bcd", bcd_a, 0);   chk("abort_ovf", ovf_a, 0);
    chk("abort_bcd_b", bcd_b, 0); chk("abort_ovf_b", ovf_b, 0);
    @(negedge clk) rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) nd++;
    end
    chk("abort_no_done", nd, 0);
    convert(0, 42);
    chk("after_abort_42", bcd_a, 16'h0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
